demux_lanes: RTL and testbench

Parametrised single-clock serial-to-parallel lane demultiplexer for the PHY receive path. It replaces the fixed two-level, three-clock byte demux tree with one block in the clk_4f domain. It gathers LANES consecutive words from the serial stream into a frame and presents them as LANES parallel lanes with per-lane valids. The output side has a ready/valid handshake and overflow reporting, and an optional lane-alignment input.

---
 rtl/demux_pkg.sv | 20 ++
 rtl/demux_lanes_if.sv | 37 +++
 rtl/demux_gather.sv | 95 +++++++++
 rtl/demux_lanes.sv | 66 ++++++
 tb/tb_demux_lanes.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and helpers for the demux_lanes lane demultiplexer.
// Holds the default word/lane sizing, the slot-index width function and the
// lane-slice macro used to pack/unpack lane k of a LANES*DATA_W bus.
// Optional feature macro used by this block: DEMUX_ALIGN_EN.

`ifndef DEMUX_LANE_SLICE
`define DEMUX_LANE_SLICE(k, w) ((k)*(w)) +: (w)
`endif

package demux_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LANES  = 4;

  // Width of a slot/lane index; never narrower than one bit.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_lanes_if.sv
// demux_lanes_if: serial input side and parallel frame output side of demux_lanes.
// The align input only exists when DEMUX_ALIGN_EN is defined.
// master = the PHY source / frame consumer, slave = the demultiplexer.

interface demux_lanes_if #(
  parameter int DATA_W = demux_pkg::DEF_DATA_W,
  parameter int LANES  = demux_pkg::DEF_LANES
);
  import demux_pkg::*;

  localparam int SW = lane_w(LANES);

  logic [DATA_W-1:0]       data_in;
  logic                    valid_in;
`ifdef DEMUX_ALIGN_EN
  logic                    align;
`endif
  logic [LANES*DATA_W-1:0] data_out;
  logic [LANES-1:0]        valid_out;
  logic                    frame_valid;
  logic                    frame_ready;
  logic                    ovf;
  logic [SW-1:0]           slot;

`ifdef DEMUX_ALIGN_EN
  modport master (output data_in, valid_in, align, frame_ready,
                  input  data_out, valid_out, frame_valid, ovf, slot);
  modport slave  (input  data_in, valid_in, align, frame_ready,
                  output data_out, valid_out, frame_valid, ovf, slot);
`else
  modport master (output data_in, valid_in, frame_ready,
                  input  data_out, valid_out, frame_valid, ovf, slot);
  modport slave  (input  data_in, valid_in, frame_ready,
                  output data_out, valid_out, frame_valid, ovf, slot);
`endif

endinterface

// File: rtl/demux_gather.sv
// demux_gather: slot counter, gather register and per-slot valids.
// Raises done on the advance that fills the last slot and presents the completed
// frame (stored words plus the current word) on frame_data/frame_vld.
// With DEMUX_ALIGN_EN, align restarts the gather with the current word in slot 0.

module demux_gather
  import demux_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LANES   = DEF_LANES,
  parameter int SLOTTED = 1
) (
  input  logic                      clk_4f,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      valid_in,
`ifdef DEMUX_ALIGN_EN
  input  logic                      align,
`endif
  output logic [lane_w(LANES)-1:0]  slot,
  output logic                      done,
  output logic [LANES*DATA_W-1:0]   frame_data,
  output logic [LANES-1:0]          frame_vld
);

  localparam int SW = lane_w(LANES);
  localparam logic [SW-1:0] LAST = SW'(LANES - 1);

  // Only the first LANES-1 words are stored; the last one is taken live from data_in.
  logic [DATA_W-1:0] gather [LANES-1];
  logic [LANES-2:0]  gvalid;
  logic              advance;
  logic              align_hit;

  assign advance = (SLOTTED != 0) ? 1'b1 : valid_in;

`ifdef DEMUX_ALIGN_EN
  assign align_hit = align;
`else
  assign align_hit = 1'b0;
`endif

  // Alignment wins over completion, so an aligned last slot never completes.
  assign done = advance && (slot == LAST) && !align_hit;

  // Assemble the completed frame: stored slots plus the word arriving now.
  always_comb begin
    frame_data = '0;
    frame_vld  = '0;
    for (int k = 0; k < LANES - 1; k++) begin
      frame_data[`DEMUX_LANE_SLICE(k, DATA_W)] = gather[k];
      frame_vld[k]                             = gvalid[k];
    end
    frame_data[`DEMUX_LANE_SLICE(LANES - 1, DATA_W)] = data_in;
    frame_vld[LANES-1]                               = valid_in;
  end

  // Slot counter and per-slot valids; cleared after every completion or align.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      slot   <= '0;
      gvalid <= '0;
    end else if (align_hit) begin
      gvalid <= '0;
      if (advance) begin
        gvalid[0] <= valid_in;
        slot      <= SW'(1);
      end else begin
        slot <= '0;
      end
    end else if (advance) begin
      if (slot == LAST) begin
        gvalid <= '0;
        slot   <= '0;
      end else begin
        for (int k = 0; k < LANES - 1; k++) begin
          if (slot == SW'(k)) gvalid[k] <= valid_in;
        end
        slot <= slot + 1'b1;
      end
    end
  end

  // Word storage; contents behind a cleared valid are don't-care, so no reset.
  always_ff @(posedge clk_4f) begin
    if (align_hit) begin
      gather[0] <= data_in;
    end else if (advance) begin
      for (int k = 0; k < LANES - 1; k++) begin
        if (slot == SW'(k)) gather[k] <= data_in;
      end
    end
  end

endmodule

// File: rtl/demux_lanes.sv
// demux_lanes: single-clock serial-to-parallel lane demultiplexer (clk_4f domain).
// Gathers LANES words into a frame, holds it on data_out/valid_out under a
// ready/valid handshake and pulses ovf when a completed frame finds the output busy.
// Optional lane-alignment input enabled by DEMUX_ALIGN_EN.

module demux_lanes
  import demux_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LANES   = DEF_LANES,
  parameter int SLOTTED = 1
) (
  input  logic          clk_4f,
  input  logic          reset,
  demux_lanes_if.slave  bus
);

  logic                    done;
  logic [LANES*DATA_W-1:0] frame_data;
  logic [LANES-1:0]        frame_vld;
  logic                    present;
  logic                    out_free;

  demux_gather #(
    .DATA_W  (DATA_W),
    .LANES   (LANES),
    .SLOTTED (SLOTTED)
  ) u_gather (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .data_in    (bus.data_in),
    .valid_in   (bus.valid_in),
`ifdef DEMUX_ALIGN_EN
    .align      (bus.align),
`endif
    .slot       (bus.slot),
    .done       (done),
    .frame_data (frame_data),
    .frame_vld  (frame_vld)
  );

  // Frames with no valid word are silently discarded.
  assign present  = done && (|frame_vld);
  // The held frame leaves this cycle if it is being accepted.
  assign out_free = !bus.frame_valid || bus.frame_ready;

  // Output register, handshake and overflow pulse.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      bus.data_out    <= '0;
      bus.valid_out   <= '0;
      bus.frame_valid <= 1'b0;
      bus.ovf         <= 1'b0;
    end else begin
      bus.ovf <= present && !out_free;
      if (present && out_free) begin
        bus.data_out    <= frame_data;
        bus.valid_out   <= frame_vld;
        bus.frame_valid <= 1'b1;
      end else if (bus.frame_ready) begin
        bus.frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux_lanes.sv
// tb_demux_lanes: bench for demux_lanes with a time-slotted (u_s) and a packed (u_p)
// instance on one clock. Expected frames are queued when their last word is driven
// and compared when the DUT presents them. Align scenarios need DEMUX_ALIGN_EN.

module tb_demux_lanes;
  import demux_pkg::*;

  localparam int DW = 8;
  localparam int LN = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  vld;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_lanes_if #(.DATA_W(DW), .LANES(LN)) bus_s ();
  demux_lanes_if #(.DATA_W(DW), .LANES(LN)) bus_p ();

  demux_lanes #(.DATA_W(DW), .LANES(LN), .SLOTTED(1)) u_s (
    .clk_4f (clk),
    .reset  (rst),
    .bus    (bus_s.slave)
  );

  demux_lanes #(.DATA_W(DW), .LANES(LN), .SLOTTED(0)) u_p (
    .clk_4f (clk),
    .reset  (rst),
    .bus    (bus_p.slave)
  );

  frame_t sb_s[$];
  frame_t sb_p[$];
  frame_t exp_f;
  int checks = 0;
  int failures = 0;
  int s_slot = 0;
  int p_slot = 0;

  function automatic frame_t mk(input logic [7:0] b, input logic [3:0] v);
    frame_t f;
    f.data = {8'(b + 8'd3), 8'(b + 8'd2), 8'(b + 8'd1), b};
    f.vld  = v;
    return f;
  endfunction

  // One clock: inputs applied at the falling edge, DUT samples at the next rising edge.
  task automatic step(input logic [7:0] ds, input logic vs, input logic [7:0] dp,
                      input logic vp, input logic al);
    bus_s.data_in  = ds;
    bus_s.valid_in = vs;
    bus_p.data_in  = dp;
    bus_p.valid_in = vp;
`ifdef DEMUX_ALIGN_EN
    bus_s.align = al;
    bus_p.align = 1'b0;
`endif
    @(negedge clk);
    s_slot = al ? 1 : (s_slot + 1) % LN;
    if (vp) p_slot = (p_slot + 1) % LN;
  endtask

  task automatic sync_slot();
    while (s_slot != 0) step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_s(input logic [7:0] b, input logic [3:0] v, input logic push);
    for (int k = 0; k < LN; k++) begin
      if (k == LN - 1 && push) sb_s.push_back(mk(b, v));
      step(8'(b + 8'(k)), v[k], 8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_s.data_in = '0; bus_s.valid_in = 1'b0; bus_s.frame_ready = 1'b1;
    bus_p.data_in = '0; bus_p.valid_in = 1'b0; bus_p.frame_ready = 1'b1;
`ifdef DEMUX_ALIGN_EN
    bus_s.align = 1'b0; bus_p.align = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_s.data_out, bus_s.valid_out, bus_s.frame_valid, bus_s.ovf, bus_s.slot} !== '0) begin
      failures++;
      $display("FAIL reset_s got=%h/%b/%b/%b/%0d want all zero", bus_s.data_out, bus_s.valid_out,
               bus_s.frame_valid, bus_s.ovf, bus_s.slot);
    end
    checks++;
    if ({bus_p.data_out, bus_p.valid_out, bus_p.frame_valid, bus_p.ovf, bus_p.slot} !== '0) begin
      failures++;
      $display("FAIL reset_p got=%h/%b/%b/%b/%0d want all zero", bus_p.data_out, bus_p.valid_out,
               bus_p.frame_valid, bus_p.ovf, bus_p.slot);
    end
    rst = 1'b0;
    s_slot = 0;
    p_slot = 0;
  endtask

  task automatic test_full_frame();
    bus_s.frame_ready = 1'b1;
    for (int k = 0; k < 3; k++) step(8'(8'h10 + 8'(k)), 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus_s.frame_valid !== 1'b0) begin
      failures++; $display("FAIL full_early_fv got=%b want=0", bus_s.frame_valid);
    end
    sb_s.push_back(mk(8'h10, 4'b1111));
    step(8'h13, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus_s.frame_valid !== 1'b1 || bus_s.ovf !== 1'b0) begin
      failures++; $display("FAIL full_fv got fv=%b ovf=%b want fv=1 ovf=0", bus_s.frame_valid, bus_s.ovf);
    end
    checks++;
    if (sb_s.size() == 0) begin
      failures++; $display("FAIL full_sb got=empty want=frame");
    end else begin
      exp_f = sb_s.pop_front();
      if ({bus_s.data_out, bus_s.valid_out} !== {exp_f.data, exp_f.vld}) begin
        failures++;
        $display("FAIL full_data got=%h/%b want=%h/%b", bus_s.data_out, bus_s.valid_out, exp_f.data, exp_f.vld);
      end
    end
    checks++;
    if (bus_s.slot !== 2'(s_slot)) begin
      failures++; $display("FAIL full_slot got=%0d want=%0d", bus_s.slot, s_slot);
    end
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus_s.frame_valid !== 1'b0) begin
      failures++; $display("FAIL full_fv_drop got=%b want=0", bus_s.frame_valid);
    end
  endtask

  task automatic test_partial_valid();
    sync_slot();
    bus_s.frame_ready = 1'b1;
    send_s(8'h20, 4'b1101, 1'b1);
    checks++;
    if (sb_s.size() == 0 || bus_s.frame_valid !== 1'b1) begin
      failures++; $display("FAIL partial_fv got=%b want=1", bus_s.frame_valid);
    end else begin
      exp_f = sb_s.pop_front();
      if ({bus_s.data_out, bus_s.valid_out} !== {exp_f.data, exp_f.vld}) begin
        failures++;
        $display("FAIL partial_data got=%h/%b want=%h/%b", bus_s.data_out, bus_s.valid_out, exp_f.data, exp_f.vld);
      end
    end
    send_s(8'h28, 4'b0000, 1'b0);
    checks++;
    if (bus_s.frame_valid !== 1'b0 || bus_s.ovf !== 1'b0) begin
      failures++; $display("FAIL invalid_frame got fv=%b ovf=%b want 0/0", bus_s.frame_valid, bus_s.ovf);
    end
  endtask

  task automatic test_packed();
    logic [7:0] pd [7];
    logic       pv [7];
    pd = '{8'hA1, 8'hEE, 8'hEE, 8'hB2, 8'hC3, 8'hEE, 8'hD4};
    pv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bus_p.frame_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) sb_p.push_back('{data: 32'hD4C3B2A1, vld: 4'b1111});
      step(8'h00, 1'b0, pd[k], pv[k], 1'b0);
      if (k == 5) begin
        checks++;
        if (bus_p.frame_valid !== 1'b0 || bus_p.slot !== 2'(p_slot)) begin
          failures++; $display("FAIL packed_early got fv=%b slot=%0d want 0/%0d", bus_p.frame_valid, bus_p.slot, p_slot);
        end
      end
    end
    checks++;
    if (sb_p.size() == 0 || bus_p.frame_valid !== 1'b1) begin
      failures++; $display("FAIL packed_fv got=%b want=1", bus_p.frame_valid);
    end else begin
      exp_f = sb_p.pop_front();
      if ({bus_p.data_out, bus_p.valid_out} !== {exp_f.data, exp_f.vld}) begin
        failures++;
        $display("FAIL packed_data got=%h/%b want=%h/%b", bus_p.data_out, bus_p.valid_out, exp_f.data, exp_f.vld);
      end
    end
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus_p.frame_valid !== 1'b0 || bus_s.frame_valid !== 1'b0) begin
      failures++; $display("FAIL packed_drop got p=%b s=%b want 0/0", bus_p.frame_valid, bus_s.frame_valid);
    end
  endtask

  task automatic test_overflow();
    sync_slot();
    bus_s.frame_ready = 1'b0;
    send_s(8'h30, 4'b1111, 1'b1);
    checks++;
    if (sb_s.size() == 0 || bus_s.frame_valid !== 1'b1) begin
      failures++; $display("FAIL ovf_first_fv got=%b want=1", bus_s.frame_valid);
    end else begin
      exp_f = sb_s.pop_front();
      if ({bus_s.data_out, bus_s.valid_out} !== {exp_f.data, exp_f.vld}) begin
        failures++;
        $display("FAIL ovf_first_data got=%h/%b want=%h/%b", bus_s.data_out, bus_s.valid_out, exp_f.data, exp_f.vld);
      end
    end
    for (int k = 0; k < 3; k++) step(8'(8'h40 + 8'(k)), 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({bus_s.data_out, bus_s.valid_out, bus_s.frame_valid, bus_s.ovf} !== {exp_f.data, exp_f.vld, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL ovf_hold got=%h/%b/%b/%b want=%h/%b/1/0", bus_s.data_out, bus_s.valid_out,
               bus_s.frame_valid, bus_s.ovf, exp_f.data, exp_f.vld);
    end
    step(8'h43, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({bus_s.data_out, bus_s.ovf} !== {exp_f.data, 1'b1}) begin
      failures++; $display("FAIL ovf_pulse got data=%h ovf=%b want %h/1", bus_s.data_out, bus_s.ovf, exp_f.data);
    end
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus_s.ovf !== 1'b0 || bus_s.frame_valid !== 1'b1 || bus_s.data_out !== exp_f.data) begin
      failures++; $display("FAIL ovf_once got ovf=%b fv=%b data=%h want 0/1/%h", bus_s.ovf,
                           bus_s.frame_valid, bus_s.data_out, exp_f.data);
    end
    bus_s.frame_ready = 1'b1;
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus_s.frame_valid !== 1'b0) begin
      failures++; $display("FAIL ovf_release got fv=%b want=0", bus_s.frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    sync_slot();
    bus_s.frame_ready = 1'b0;
    send_s(8'h50, 4'b1111, 1'b1);
    checks++;
    if (sb_s.size() == 0 || bus_s.frame_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_first_fv got=%b want=1", bus_s.frame_valid);
    end else begin
      exp_f = sb_s.pop_front();
      if (bus_s.data_out !== exp_f.data) begin
        failures++; $display("FAIL b2b_first_data got=%h want=%h", bus_s.data_out, exp_f.data);
      end
    end
    for (int k = 0; k < 3; k++) step(8'(8'h70 + 8'(k)), 1'b1, 8'h00, 1'b0, 1'b0);
    bus_s.frame_ready = 1'b1;
    sb_s.push_back(mk(8'h70, 4'b1111));
    step(8'h73, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus_s.frame_valid !== 1'b1 || bus_s.ovf !== 1'b0) begin
      failures++; $display("FAIL b2b_fv got fv=%b ovf=%b want 1/0", bus_s.frame_valid, bus_s.ovf);
    end
    checks++;
    if (sb_s.size() == 0) begin
      failures++; $display("FAIL b2b_sb got=empty want=frame");
    end else begin
      exp_f = sb_s.pop_front();
      if ({bus_s.data_out, bus_s.valid_out} !== {exp_f.data, exp_f.vld}) begin
        failures++;
        $display("FAIL b2b_data got=%h/%b want=%h/%b", bus_s.data_out, bus_s.valid_out, exp_f.data, exp_f.vld);
      end
    end
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus_s.frame_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_drop got fv=%b want=0", bus_s.frame_valid);
    end
  endtask

  task automatic test_reset_midframe();
    sync_slot();
    bus_s.frame_ready = 1'b0;
    send_s(8'h80, 4'b1111, 1'b0);
    step(8'h90, 1'b1, 8'h00, 1'b0, 1'b0);
    step(8'h91, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus_s.frame_valid !== 1'b1 || bus_s.slot !== 2'd2) begin
      failures++; $display("FAIL midrst_pre got fv=%b slot=%0d want 1/2", bus_s.frame_valid, bus_s.slot);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus_s.data_out, bus_s.valid_out, bus_s.frame_valid, bus_s.ovf, bus_s.slot} !== '0) begin
      failures++;
      $display("FAIL midrst_async got=%h/%b/%b/%b/%0d want all zero", bus_s.data_out, bus_s.valid_out,
               bus_s.frame_valid, bus_s.ovf, bus_s.slot);
    end
    @(negedge clk);
    rst = 1'b0;
    s_slot = 0;
    p_slot = 0;
    bus_s.frame_ready = 1'b1;
    send_s(8'h60, 4'b1111, 1'b1);
    checks++;
    if (sb_s.size() == 0 || bus_s.frame_valid !== 1'b1) begin
      failures++; $display("FAIL midrst_fv got=%b want=1", bus_s.frame_valid);
    end else begin
      exp_f = sb_s.pop_front();
      if ({bus_s.data_out, bus_s.valid_out} !== {exp_f.data, exp_f.vld}) begin
        failures++;
        $display("FAIL midrst_data got=%h/%b want=%h/%b", bus_s.data_out, bus_s.valid_out, exp_f.data, exp_f.vld);
      end
    end
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

`ifdef DEMUX_ALIGN_EN
  task automatic test_align();
    sync_slot();
    bus_s.frame_ready = 1'b1;
    step(8'hA0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(8'hA1, 1'b1, 8'h00, 1'b0, 1'b0);
    step(8'h55, 1'b1, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus_s.slot !== 2'd1 || bus_s.frame_valid !== 1'b0 || bus_s.ovf !== 1'b0) begin
      failures++; $display("FAIL align_slot got slot=%0d fv=%b ovf=%b want 1/0/0", bus_s.slot,
                           bus_s.frame_valid, bus_s.ovf);
    end
    step(8'h56, 1'b1, 8'h00, 1'b0, 1'b0);
    step(8'h57, 1'b1, 8'h00, 1'b0, 1'b0);
    sb_s.push_back(mk(8'h55, 4'b1111));
    step(8'h58, 1'b1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (sb_s.size() == 0 || bus_s.frame_valid !== 1'b1 || bus_s.ovf !== 1'b0) begin
      failures++; $display("FAIL align_fv got fv=%b ovf=%b want 1/0", bus_s.frame_valid, bus_s.ovf);
    end else begin
      exp_f = sb_s.pop_front();
      if ({bus_s.data_out, bus_s.valid_out} !== {exp_f.data, exp_f.vld}) begin
        failures++;
        $display("FAIL align_data got=%h/%b want=%h/%b", bus_s.data_out, bus_s.valid_out, exp_f.data, exp_f.vld);
      end
    end
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    sync_slot();
    for (int k = 0; k < 3; k++) step(8'(8'hB0 + 8'(k)), 1'b1, 8'h00, 1'b0, 1'b0);
    step(8'hB3, 1'b1, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus_s.frame_valid !== 1'b0 || bus_s.ovf !== 1'b0 || bus_s.slot !== 2'd1) begin
      failures++; $display("FAIL align_last got fv=%b ovf=%b slot=%0d want 0/0/1", bus_s.frame_valid,
                           bus_s.ovf, bus_s.slot);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_partial_valid();
    test_packed();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
`ifdef DEMUX_ALIGN_EN
    test_align();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
